// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder with wait states and pipeline stall.
module dmem_responder #(
  parameter int AW          = 5,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          ready,
  output logic          rvalid,
  output logic [31:0]   rdata,
  output logic          stall
);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0]     mem_q [2**AW];
  logic [31:0]     mem_d [2**AW];
  logic            accept, commit, c_we;
  logic [AW-1:0]   c_addr;
  logic [31:0]     c_wdata;
  always_comb begin
    accept  = state_q == S_IDLE && req;
    commit  = (state_q == S_WAIT && cnt_q == 4'd0) || (accept && WAIT_CYCLES == 0);
    // with zero wait states the commit happens on the accept edge, before capture
    c_we    = accept ? we : we_q;
    c_addr  = accept ? addr : addr_q;
    c_wdata = accept ? wdata : wdata_q;
    we_d    = accept ? we : we_q;
    addr_d  = accept ? addr : addr_q;
    wdata_d = accept ? wdata : wdata_q;
    state_d = accept ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT)
            : state_q == S_WAIT ? (cnt_q == 4'd0 ? S_RESP : S_WAIT) : S_IDLE;
    cnt_d   = accept ? CNT_INIT : (state_q == S_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    mem_d   = mem_q;
    if (commit && c_we) mem_d[c_addr] = c_wdata;
    rdata_d = commit ? (c_we ? c_wdata : mem_q[c_addr]) : rdata_q;
  end
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mem_q   <= mem_d;
    end
  end
  assign ready  = state_q == S_IDLE;
  assign rvalid = state_q == S_RESP;
  assign rdata  = rdata_q;
  assign stall  = accept || state_q == S_WAIT;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of two responders (2 wait states and zero wait states).
module tb_dmem_responder;
  logic        Clock = 1'b0, Resetn = 1'b0;
  logic        req = 1'b1, we = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [4:0]  addr = '0, addr1 = '0;
  logic [31:0] wdata = '0, wdata1 = '0, rdata, rdata1, r;
  logic        ready, rvalid, stall, ready1, rvalid1, stall1, ok;
  int          checks = 0, errors = 0, lat;
  logic [4:0]  bb_addr [8] = '{5'd0, 5'd31, 5'd31, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0};
  logic [31:0] bb_data [8] = '{32'hAAAA0000, 32'h1, 32'h2, 32'h3, 32'hBBBB1111, 32'h5, 32'h6, 32'h7};

  dmem_responder #(.AW(5), .WAIT_CYCLES(2)) u0 (
    .Clock(Clock), .Resetn(Resetn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .stall(stall));
  dmem_responder #(.AW(5), .WAIT_CYCLES(0)) u1 (
    .Clock(Clock), .Resetn(Resetn), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .ready(ready1), .rvalid(rvalid1), .rdata(rdata1), .stall(stall1));

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // one transaction on u0 starting in an IDLE cycle; returns rdata at rvalid and cycles after accept
  task automatic xact(input logic w, input logic [4:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic got, output int l);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0;
    got = 1'b0; rd = '0; l = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      #2;
      if (rvalid) begin got = 1'b1; rd = rdata; l = k; end
      tick();
    end
  endtask

  initial begin
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_stall_req", stall, 1);
    #10;
    Resetn = 1'b1; req = 1'b0;
    #1;
    chk("rel_stall", stall, 0);
    chk("rel_ready", ready, 1);
    tick();
    // store 0xDEADBEEF to 7, cycle by cycle
    req = 1'b1; we = 1'b1; addr = 5'd7; wdata = 32'hDEADBEEF;
    #2; chk("st_c0_stall", stall, 1); chk("st_c0_ready", ready, 1);
    tick(); req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #2; chk("st_c1_stall", stall, 1); chk("st_c1_ready", ready, 0); chk("st_c1_rvalid", rvalid, 0);
    tick();
    #2; chk("st_c2_stall", stall, 1); chk("st_c2_rvalid", rvalid, 0);
    tick();
    #2; chk("st_c3_rvalid", rvalid, 1); chk("st_c3_rdata", rdata, 32'hDEADBEEF);
    chk("st_c3_stall", stall, 0); chk("st_c3_ready", ready, 0);
    tick();
    #2; chk("st_c4_ready", ready, 1); chk("st_c4_rvalid", rvalid, 0); chk("st_c4_rdata_hold", rdata, 32'hDEADBEEF);
    tick();
    xact(1'b0, 5'd7, 32'h0, r, ok, lat);
    chk("ld7_valid", ok, 1); chk("ld7_lat", lat, 3); chk("ld7_data", r, 32'hDEADBEEF);
    // zero-wait instance: preload address 3, then load it
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd3; wdata1 = 32'h12345678;
    tick(); req1 = 1'b0;
    #2; chk("z_st_rvalid", rvalid1, 1);
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd3; wdata1 = '0;
    #2; chk("z_c0_stall", stall1, 1); chk("z_c0_ready", ready1, 1); chk("z_c0_rvalid", rvalid1, 0);
    tick(); req1 = 1'b0;
    #2; chk("z_c1_rvalid", rvalid1, 1); chk("z_c1_rdata", rdata1, 32'h12345678);
    chk("z_c1_stall", stall1, 0); chk("z_c1_ready", ready1, 0);
    tick();
    #2; chk("z_c2_ready", ready1, 1); chk("z_c2_rvalid", rvalid1, 0);
    tick();
    // back-to-back stores with req held for 8 cycles
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; we = 1'b1; addr = bb_addr[i]; wdata = bb_data[i];
      #2;
      chk($sformatf("bb_ready_c%0d", i), ready, (i % 4 == 0) ? 1 : 0);
      chk($sformatf("bb_rvalid_c%0d", i), rvalid, (i % 4 == 3) ? 1 : 0);
      chk($sformatf("bb_stall_c%0d", i), stall, (i % 4 == 3) ? 0 : 1);
      if (i == 3) chk("bb_rdata_c3", rdata, 32'hAAAA0000);
      if (i == 7) chk("bb_rdata_c7", rdata, 32'hBBBB1111);
      tick();
    end
    req = 1'b0;
    #2; chk("bb_c8_ready", ready, 1);
    tick();
    xact(1'b0, 5'd0, 32'h0, r, ok, lat);
    chk("bb_ld0_valid", ok, 1); chk("bb_ld0", r, 32'hAAAA0000);
    xact(1'b0, 5'd31, 32'h0, r, ok, lat);
    chk("bb_ld31_valid", ok, 1); chk("bb_ld31", r, 32'hBBBB1111);
    // reset during WAIT abandons the store
    req = 1'b1; we = 1'b1; addr = 5'd9; wdata = 32'hA5A5A5A5;
    tick(); req = 1'b0;
    Resetn = 1'b0;
    #2; chk("mr_ready", ready, 1); chk("mr_rvalid", rvalid, 0); chk("mr_rdata", rdata, 0);
    Resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #2; chk($sformatf("mr_no_rvalid_%0d", i), rvalid, 0);
    end
    tick();
    xact(1'b0, 5'd9, 32'h0, r, ok, lat);
    chk("mr_ld9_valid", ok, 1); chk("mr_ld9", r, 32'h0);
    xact(1'b0, 5'd7, 32'h0, r, ok, lat);
    chk("mr_ld7_cleared", r, 32'h0);
    // inputs change after accept
    req = 1'b1; we = 1'b1; addr = 5'd12; wdata = 32'hCAFEF00D;
    tick(); req = 1'b0; we = 1'b0; addr = 5'd13; wdata = 32'h0BADF00D;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      #2;
      if (rvalid) begin ok = 1'b1; chk("ic_rdata", rdata, 32'hCAFEF00D); end
      tick();
    end
    chk("ic_valid", ok, 1);
    xact(1'b0, 5'd12, 32'h0, r, ok, lat);
    chk("ic_ld12", r, 32'hCAFEF00D);
    xact(1'b0, 5'd13, 32'h0, r, ok, lat);
    chk("ic_ld13", r, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
